// File: rtl/std_onehot_pipe_pkg.sv
// Shared types and helpers for the one-hot/popcount checking pipeline.
// Rule encoding matches the i_mode port values.
package std_onehot_pipe_pkg;

  typedef enum logic [1:0] {
    ONEHOT         = 2'd0,
    ONEHOT_OR_ZERO = 2'd1,
    ZERO           = 2'd2,
    NONE           = 2'd3
  } mode_e;

  // Bits needed to hold a population count of a w-bit vector (0..w).
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic rule_violated(
    input mode_e mode,
    input logic  zero,
    input logic  onehot,
    input logic  gt_one
  );
    logic viol;
    viol = 1'b0;
    case (mode)
      ONEHOT:         viol = ~onehot;
      ONEHOT_OR_ZERO: viol = gt_one;
      ZERO:           viol = ~zero;
      default:        viol = 1'b0;
    endcase
    return viol;
  endfunction

endpackage

// File: rtl/std_popcount.sv
// Combinational population count built as a recursive halving tree.
// Each node also merges the zero/onehot/gt_one flags of its two halves.
module std_popcount
  import std_onehot_pipe_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = count_width(W)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          onehot,
  output logic          gt_one
);

  generate
    if (W == 1) begin : g_leaf
      assign count  = CW'(data);
      assign zero   = ~data[0];
      assign onehot = data[0];
      assign gt_one = 1'b0;
    end else begin : g_node
      localparam int LW  = W / 2;
      localparam int HW  = W - LW;
      localparam int LCW = count_width(LW);
      localparam int HCW = count_width(HW);

      logic [LCW-1:0] lo_count;
      logic [HCW-1:0] hi_count;
      logic           lo_zero, lo_onehot, lo_gt_one;
      logic           hi_zero, hi_onehot, hi_gt_one;

      std_popcount #(.W(LW), .CW(LCW)) u_lo (
        .data   (data[LW-1:0]),
        .count  (lo_count),
        .zero   (lo_zero),
        .onehot (lo_onehot),
        .gt_one (lo_gt_one)
      );

      std_popcount #(.W(HW), .CW(HCW)) u_hi (
        .data   (data[W-1:LW]),
        .count  (hi_count),
        .zero   (hi_zero),
        .onehot (hi_onehot),
        .gt_one (hi_gt_one)
      );

      assign count  = CW'(lo_count) + CW'(hi_count);
      assign zero   = lo_zero & hi_zero;
      assign onehot = (lo_onehot & hi_zero) | (lo_zero & hi_onehot);
      assign gt_one = lo_gt_one | hi_gt_one | (lo_onehot & hi_onehot);
    end
  endgenerate

endmodule

// File: rtl/std_onehot_pipe.sv
// Checked pass-through stage: classifies each beat, carries it down a stalling
// register pipeline with its own rule, and monitors emitted violations.
module std_onehot_pipe
  import std_onehot_pipe_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 2,
  parameter int ERRW   = 8,
  localparam int CW    = count_width(W)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [W-1:0]    i_data,
  input  logic [1:0]      i_mode,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [W-1:0]    o_data,
  output logic [CW-1:0]   o_count,
  output logic            o_zero,
  output logic            o_onehot,
  output logic            o_gt_one,
  output logic            o_viol,
  input  logic            i_clear,
  output logic            o_err_sticky,
  output logic [ERRW-1:0] o_err_count,
  output logic [W-1:0]    o_err_data
);

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  data;
    logic [CW-1:0] count;
    logic          zero;
    logic          onehot;
    logic          gt_one;
    mode_e         mode;
  } slot_t;

  // An empty payload still classifies as zero.
  localparam slot_t SLOT_RESET = '{
    valid:  1'b0,
    data:   '0,
    count:  '0,
    zero:   1'b1,
    onehot: 1'b0,
    gt_one: 1'b0,
    mode:   NONE
  };

  logic [CW-1:0] in_count;
  logic          in_zero;
  logic          in_onehot;
  logic          in_gt_one;
  slot_t         in_slot;

  slot_t slot_q [STAGES];
  slot_t slot_d [STAGES];

  logic            err_sticky_q, err_sticky_d;
  logic [ERRW-1:0] err_count_q,  err_count_d;
  logic [W-1:0]    err_data_q,   err_data_d;
  logic            out_fire_viol;

  std_popcount #(.W(W), .CW(CW)) u_popcount (
    .data   (i_data),
    .count  (in_count),
    .zero   (in_zero),
    .onehot (in_onehot),
    .gt_one (in_gt_one)
  );

  always_comb begin
    in_slot        = SLOT_RESET;
    in_slot.valid  = i_valid;
    in_slot.data   = i_data;
    in_slot.count  = in_count;
    in_slot.zero   = in_zero;
    in_slot.onehot = in_onehot;
    in_slot.gt_one = in_gt_one;
    in_slot.mode   = mode_e'(i_mode);
  end

  // One global stall: the whole pipeline advances only when the tail can move.
  assign o_ready = ~slot_q[STAGES-1].valid | i_ready;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      slot_d[s] = slot_q[s];
    end
    if (o_ready) begin
      slot_d[0] = in_slot;
      for (int s = 1; s < STAGES; s++) begin
        slot_d[s] = slot_q[s-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int s = 0; s < STAGES; s++) begin
        slot_q[s] <= SLOT_RESET;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        slot_q[s] <= slot_d[s];
      end
    end
  end

  assign o_valid  = slot_q[STAGES-1].valid;
  assign o_data   = slot_q[STAGES-1].data;
  assign o_count  = slot_q[STAGES-1].count;
  assign o_zero   = slot_q[STAGES-1].zero;
  assign o_onehot = slot_q[STAGES-1].onehot;
  assign o_gt_one = slot_q[STAGES-1].gt_one;
  assign o_viol   = slot_q[STAGES-1].valid &
                    rule_violated(slot_q[STAGES-1].mode, slot_q[STAGES-1].zero,
                                  slot_q[STAGES-1].onehot, slot_q[STAGES-1].gt_one);

  assign out_fire_viol = o_valid & i_ready & o_viol;

  // Clear is applied first so a same-cycle violation becomes the new first offender.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    err_data_d   = err_data_q;
    if (i_clear) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
      err_data_d   = '0;
    end
    if (out_fire_viol) begin
      if (!err_sticky_d) begin
        err_data_d = o_data;
      end
      err_sticky_d = 1'b1;
      if (err_count_d != '1) begin
        err_count_d = err_count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      err_data_q   <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      err_data_q   <= err_data_d;
    end
  end

  assign o_err_sticky = err_sticky_q;
  assign o_err_count  = err_count_q;
  assign o_err_data   = err_data_q;

endmodule

// File: tb/tb_std_onehot_pipe.sv
// Directed bench for std_onehot_pipe (W=8, STAGES=2) plus a saturation instance
// (ERRW=2) and an exhaustive popcount sweep over widths 1..10.
module tb_std_onehot_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_n;
  logic       in_valid, in_ready, in_clear;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_ready, out_valid, out_zero, out_onehot, out_gt_one, out_viol;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       err_sticky;
  logic [7:0] err_count;
  logic [7:0] err_data;

  std_onehot_pipe #(.W(8), .STAGES(2), .ERRW(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_valid      (in_valid),
    .o_ready      (out_ready),
    .i_data       (in_data),
    .i_mode       (in_mode),
    .o_valid      (out_valid),
    .i_ready      (in_ready),
    .o_data       (out_data),
    .o_count      (out_count),
    .o_zero       (out_zero),
    .o_onehot     (out_onehot),
    .o_gt_one     (out_gt_one),
    .o_viol       (out_viol),
    .i_clear      (in_clear),
    .o_err_sticky (err_sticky),
    .o_err_count  (err_count),
    .o_err_data   (err_data)
  );

  logic       v2, r2, c2;
  logic [7:0] d2;
  logic [1:0] m2;
  logic       ordy2, ov2, oz2, oo2, og2, oviol2;
  logic [7:0] od2;
  logic [3:0] oc2;
  logic       sticky2;
  logic [1:0] ecount2;
  logic [7:0] edata2;

  std_onehot_pipe #(.W(8), .STAGES(2), .ERRW(2)) dut2 (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_valid      (v2),
    .o_ready      (ordy2),
    .i_data       (d2),
    .i_mode       (m2),
    .o_valid      (ov2),
    .i_ready      (r2),
    .o_data       (od2),
    .o_count      (oc2),
    .o_zero       (oz2),
    .o_onehot     (oo2),
    .o_gt_one     (og2),
    .o_viol       (oviol2),
    .i_clear      (c2),
    .o_err_sticky (sticky2),
    .o_err_count  (ecount2),
    .o_err_data   (edata2)
  );

  logic [9:0] sweep;
  logic [3:0] pc_count [1:10];
  logic [2:0] pc_flags [1:10];

  for (genvar gi = 1; gi <= 10; gi++) begin : g_pc
    localparam int CWI = $clog2(gi + 1);
    logic [CWI-1:0] c;
    logic z, o, g;
    std_popcount #(.W(gi), .CW(CWI)) u_pc (
      .data   (sweep[gi-1:0]),
      .count  (c),
      .zero   (z),
      .onehot (o),
      .gt_one (g)
    );
    assign pc_count[gi] = 4'(c);
    assign pc_flags[gi] = {z, o, g};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0; in_clear = 1'b0;
    in_data = 8'h00; in_mode = 2'd0;
    v2 = 1'b0; r2 = 1'b1; c2 = 1'b0; d2 = 8'h00; m2 = 2'd2;
    sweep = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", out_data); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", out_count); end
    checks++; if ({out_zero, out_onehot, out_gt_one, out_viol} !== 4'b1000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 1000", {out_zero, out_onehot, out_gt_one, out_viol}); end
    checks++; if ({err_sticky, err_count, err_data} !== 17'h0) begin errors++; $display("[TB] FAIL reset_monitor: got %h expected 0", {err_sticky, err_count, err_data}); end
    rst_n = 1'b1;
    step();
    checks++; if (out_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", out_ready); end
  endtask

  task automatic test_onehot_stream();
    logic [7:0] vec [4];
    int         exp_cnt [4];
    logic       exp_viol [4];
    vec = '{8'h01, 8'h80, 8'h00, 8'h03};
    exp_cnt = '{1, 1, 0, 2};
    exp_viol = '{1'b0, 1'b0, 1'b1, 1'b1};
    in_ready = 1'b1; in_mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      in_data = (i < 4) ? vec[i] : 8'h00;
      step();
      if (i >= 1) begin
        checks++; if ({out_valid, out_data} !== {1'b1, vec[i-1]}) begin errors++; $display("[TB] FAIL stream_data[%0d]: got %b/%h expected 1/%h", i-1, out_valid, out_data, vec[i-1]); end
        checks++; if (out_count !== 4'(exp_cnt[i-1])) begin errors++; $display("[TB] FAIL stream_count[%0d]: got %0d expected %0d", i-1, out_count, exp_cnt[i-1]); end
        checks++; if (out_viol !== exp_viol[i-1]) begin errors++; $display("[TB] FAIL stream_viol[%0d]: got %b expected %b", i-1, out_viol, exp_viol[i-1]); end
        checks++; if ({out_zero, out_onehot, out_gt_one} !== {exp_cnt[i-1] == 0, exp_cnt[i-1] == 1, exp_cnt[i-1] > 1}) begin errors++; $display("[TB] FAIL stream_flags[%0d]: got %b", i-1, {out_zero, out_onehot, out_gt_one}); end
      end
    end
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL stream_errcnt_mid: got %0d expected 1", err_count); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", out_valid); end
    checks++; if ({err_sticky, err_count, err_data} !== {1'b1, 8'd2, 8'h00}) begin errors++; $display("[TB] FAIL stream_monitor: got %b/%0d/%h expected 1/2/00", err_sticky, err_count, err_data); end
  endtask

  task automatic test_onehot_or_zero();
    in_valid = 1'b0; in_clear = 1'b1;
    step();
    in_clear = 1'b0;
    checks++; if ({err_sticky, err_count, err_data} !== 17'h0) begin errors++; $display("[TB] FAIL clear_idle: got %h expected 0", {err_sticky, err_count, err_data}); end
    in_mode = 2'd1; in_valid = 1'b1; in_data = 8'h00;
    step();
    in_data = 8'hFF;
    step();
    checks++; if ({out_valid, out_data, out_count, out_viol} !== {1'b1, 8'h00, 4'd0, 1'b0}) begin errors++; $display("[TB] FAIL ooz_zero: got %b/%h/%0d/%b expected 1/00/0/0", out_valid, out_data, out_count, out_viol); end
    in_valid = 1'b0;
    step();
    checks++; if ({out_valid, out_data, out_count, out_viol, out_gt_one} !== {1'b1, 8'hFF, 4'd8, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL ooz_full: got %b/%h/%0d/%b/%b expected 1/ff/8/1/1", out_valid, out_data, out_count, out_viol, out_gt_one); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL ooz_errcnt_mid: got %0d expected 0", err_count); end
    step();
    checks++; if ({err_sticky, err_count, err_data} !== {1'b1, 8'd1, 8'hFF}) begin errors++; $display("[TB] FAIL ooz_monitor: got %b/%0d/%h expected 1/1/ff", err_sticky, err_count, err_data); end
  endtask

  task automatic test_stall();
    in_mode = 2'd0; in_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h05;
    step();
    in_data = 8'h10;
    step();
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h05}) begin errors++; $display("[TB] FAIL stall_fill: got %b/%h expected 1/05", out_valid, out_data); end
    in_ready = 1'b0; in_data = 8'h21;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({out_ready, out_valid, out_data, out_viol} !== {1'b0, 1'b1, 8'h05, 1'b1}) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got %b/%b/%h/%b expected 0/1/05/1", k, out_ready, out_valid, out_data, out_viol); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL stall_monitor[%0d]: got %0d expected 1", k, err_count); end
    end
    in_ready = 1'b1;
    step();
    checks++; if ({out_valid, out_data, err_count} !== {1'b1, 8'h10, 8'd2}) begin errors++; $display("[TB] FAIL stall_release: got %b/%h/%0d expected 1/10/2", out_valid, out_data, err_count); end
    in_valid = 1'b0;
    step();
    checks++; if ({out_valid, out_data, err_count} !== {1'b1, 8'h21, 8'd2}) begin errors++; $display("[TB] FAIL stall_third: got %b/%h/%0d expected 1/21/2", out_valid, out_data, err_count); end
    step();
    checks++; if ({out_valid, err_sticky, err_count, err_data} !== {1'b0, 1'b1, 8'd3, 8'hFF}) begin errors++; $display("[TB] FAIL stall_drain: got %b/%b/%0d/%h expected 0/1/3/ff", out_valid, err_sticky, err_count, err_data); end
  endtask

  task automatic test_clear_same_cycle();
    in_mode = 2'd0; in_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h0C;
    step();
    in_valid = 1'b0;
    step();
    checks++; if ({out_valid, out_data, out_viol} !== {1'b1, 8'h0C, 1'b1}) begin errors++; $display("[TB] FAIL clrsame_out: got %b/%h/%b expected 1/0c/1", out_valid, out_data, out_viol); end
    in_clear = 1'b1;
    step();
    in_clear = 1'b0;
    checks++; if ({err_sticky, err_count, err_data} !== {1'b1, 8'd1, 8'h0C}) begin errors++; $display("[TB] FAIL clrsame_monitor: got %b/%0d/%h expected 1/1/0c", err_sticky, err_count, err_data); end
  endtask

  task automatic test_saturate();
    logic [7:0] beats [5];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    m2 = 2'd2; r2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v2 = (i < 5);
      d2 = (i < 5) ? beats[i] : 8'h00;
      step();
      if (i == 3) begin
        checks++; if (ecount2 !== 2'd2) begin errors++; $display("[TB] FAIL sat_mid: got %0d expected 2", ecount2); end
      end
      if (i >= 4) begin
        checks++; if (ecount2 !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold[%0d]: got %0d expected 3", i, ecount2); end
      end
    end
    checks++; if ({sticky2, edata2} !== {1'b1, 8'h11}) begin errors++; $display("[TB] FAIL sat_first: got %b/%h expected 1/11", sticky2, edata2); end
  endtask

  task automatic test_reset_midstream();
    in_mode = 2'd0; in_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_data = 8'h02;
    step();
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h01}) begin errors++; $display("[TB] FAIL midrst_pre: got %b/%h expected 1/01", out_valid, out_data); end
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    checks++; if ({out_valid, out_data} !== {1'b0, 8'h00}) begin errors++; $display("[TB] FAIL midrst_out: got %b/%h expected 0/00", out_valid, out_data); end
    checks++; if ({err_sticky, err_count, err_data, sticky2, ecount2, edata2} !== 28'h0) begin errors++; $display("[TB] FAIL midrst_monitor: got %b/%0d/%h %b/%0d/%h expected all 0", err_sticky, err_count, err_data, sticky2, ecount2, edata2); end
    rst_n = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ghost: got %b expected 0", out_valid); end
  endtask

  task automatic test_popcount_sweep();
    for (int v = 0; v < 1024; v++) begin
      sweep = 10'(v);
      #1;
      for (int w = 1; w <= 10; w++) begin
        int r;
        r = 0;
        for (int b = 0; b < w; b++) r += (v >> b) & 1;
        checks++; if (pc_count[w] !== 4'(r)) begin errors++; $display("[TB] FAIL sweep_count w=%0d v=%h: got %0d expected %0d", w, v, pc_count[w], r); end
        checks++; if (pc_flags[w] !== {r == 0, r == 1, r > 1}) begin errors++; $display("[TB] FAIL sweep_flags w=%0d v=%h: got %b expected %b", w, v, pc_flags[w], {r == 0, r == 1, r > 1}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot_stream();
    test_onehot_or_zero();
    test_stall();
    test_clear_same_cycle();
    test_saturate();
    test_reset_midstream();
    test_popcount_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/std_onehot_pipe.md
# std_onehot_pipe

Streaming one-hot/population-count checker with a parametrised register pipeline, valid/ready flow control and a violation monitor. Each accepted W-bit vector comes out STAGES cycles later, annotated with its popcount and zero/one-hot/more-than-one flags. A mode-selectable rule flags violations, which feed a sticky flag, a saturating counter and first-offender capture. Sits between arbiters or grant generators and their consumers, as a checked pass-through stage.

## Interface
- W, 16: vector width, ≥1
- STAGES, 2: pipeline register stages, ≥1
- ERRW, 8: violation counter width, ≥1
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous reset, active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid & o_ready
- i_data  in  W  vector to classify
- i_mode  in  2  check rule: 0 ONEHOT, 1 ONEHOT_OR_ZERO, 2 ZERO, 3 NONE
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_data  out  W  delayed copy of i_data
- o_count  out  CW=$clog2(W+1)  number of set bits
- o_zero / o_onehot / o_gt_one  out  1 each  count==0 / count==1 / count>1
- o_viol  out  1  this output beat breaks its rule
- i_clear  in  1  clear monitor state
- o_err_sticky  out  1  a violation has been emitted since reset/clear
- o_err_count  out  ERRW  violations emitted, saturating at all-ones
- o_err_data  out  W  o_data of first violation since reset/clear

## Operation
- Classification is combinational on i_data: count, zero, onehot and gt_one.
- i_mode is sampled with the beat and travels with it down the pipeline. o_viol is computed from the beat's own mode:
  - ONEHOT: ~onehot
  - ONEHOT_OR_ZERO: gt_one
  - ZERO: ~zero
  - NONE: 0
- Pipeline is STAGES slots, each holding {valid, data, count, flags, mode}.
- Global stall: o_ready = ~o_valid | i_ready. When o_ready=1, every slot shifts one step and slot 0 loads {i_valid, beat}. When o_ready=0, all slots hold.
- Bubbles propagate as invalid slots. No slot reordering and no bubble collapsing.
- Monitor updates only on output handshake (o_valid & i_ready & o_viol):
  - set o_err_sticky
  - increment o_err_count, saturating
  - if sticky was 0, capture o_data into o_err_data
- i_clear=1 resets sticky, count and err_data to 0 first. A violation handshake in the same cycle is then applied, giving sticky=1, count=1, err_data=that beat.
- i_clear does not affect the pipeline.

## Timing
- Reset (i_rst=0 at edge): all slot valids=0, o_valid=0, o_err_sticky=0, o_err_count=0, o_err_data=0. Slot payloads reset to 0, so o_data=0, o_count=0, o_zero=1, o_onehot=0, o_gt_one=0, o_viol=0.
- o_ready is combinational from i_ready; it is 1 in the first cycle after reset.
- Reset mid-stream drops all in-flight beats and leaves no partial state.
- Latency: beat accepted at edge n shows on o_valid at edge n+STAGES-1 (visible cycle n+STAGES) when there is no stall.
- Throughput: 1 beat/cycle while i_ready=1.
- Stall: outputs stay stable while o_valid & ~i_ready.
- Counter at 2^ERRW-1 stays there on further violations; sticky and err_data are unchanged.
- W=1: CW=1, and gt_one is always 0.

## Structure
- Package std_onehot_pipe_pkg:
  - mode_e enum (ONEHOT, ONEHOT_OR_ZERO, ZERO, NONE)
  - function count_width(W) = $clog2(W+1)
  - packed slot struct definition is parametrised locally, not in the package
- Sub-module std_popcount: combinational, recursive halving tree giving count (CW bits) plus zero/onehot/gt_one. It is instantiated once at the input.

## Test plan
- W=8, STAGES=2, mode ONEHOT, i_ready=1, stream 8'h01, 8'h80, 8'h00, 8'h03 → outputs at cycles +2: counts 1,1,0,2; o_viol 0,0,1,1; o_err_count=2; o_err_data=8'h00.
- Mode ONEHOT_OR_ZERO with 8'h00 then 8'hFF → o_viol 0 then 1, o_count=8, sticky=1.
- Hold i_ready=0 for 3 cycles with pipeline full → o_ready=0, o_data stable, no beat lost or duplicated; monitor unchanged until handshake.
- ERRW=2, mode ZERO, feed 5 nonzero beats → o_err_count saturates at 3; o_err_data = first beat.
- i_clear asserted on the same cycle as a violating handshake → sticky=1, count=1, err_data = that beat.
- Assert i_rst=0 mid-stream with 2 beats in flight → next cycle o_valid=0, all monitor outputs 0; exhaustive sweep for W=1..10 then matches reference popcount.
